softmax_row_feeder: RTL
=======================

// Module: softmax_row_feeder
// PURPOSE
// Transmit side of the softmax row input stream. Collects attention-score accumulators
// from an upstream valid/ready stream into two ping-pong row banks of N words each.
// Bursts each complete row into softmax as N back-to-back in_valid beats, then holds
// ROW_GAP idle cycles so the next row cannot collide with the previous row's
// max-buffer readout. Sits between the QK^T matmul output and softmax (qin/in_valid).
// PARAMETERS
// D_W_ACC  32      score word width (matches softmax D_W_ACC)
// N        32      row length; must equal softmax N; N >= 2
// ROW_GAP  N+4     enabled idle cycles forced after each burst before the next burst
// PORTS
// clk          in   1        clock, rising edge
// rst          in   1        asynchronous, active-low reset
// enable       in   1        global stall shared with softmax; 0 freezes the burst side
// s_valid      in   1        upstream score word valid
// s_ready      out  1        upstream may transfer this cycle
// s_data       in   D_W_ACC  upstream score word (signed)
// sm_in_valid  out  1        drives softmax in_valid
// sm_qin       out  D_W_ACC  drives softmax qin (signed)
// row_sent     out  1        one-cycle pulse on the last beat of each burst
// busy         out  1        1 when state != IDLE or either bank is full
// BEHAVIOUR
// - Reset: async on rst=0. All flags, counters and FSM clear. sm_in_valid=0, sm_qin=0,
//   row_sent=0, busy=0, s_ready=0 while rst=0. Partial rows are discarded. s_ready=1
//   from the first clock after release.
// - Fill side (independent of enable):
//   - s_ready = !full[wr_bank] && rst.
//   - On s_valid&s_ready: bank[wr_bank][wr_idx] <= s_data and wr_idx++.
//   - When wr_idx==N-1 on a transfer: full[wr_bank] <= 1, wr_idx <= 0, wr_bank toggles.
// - Burst FSM (advances only when enable=1; all outputs and state hold when enable=0):
//   - IDLE: if full[rd_bank], go to BURST with rd_idx=0.
//   - BURST: registered outputs sm_in_valid=1, sm_qin=bank[rd_bank][rd_idx], rd_idx++.
//     - On rd_idx==N-1: row_sent=1, full[rd_bank] <= 0, rd_bank toggles, gap_cnt <= 0,
//       go to GAP.
//   - GAP: sm_in_valid=0, gap_cnt++. At gap_cnt==ROW_GAP-1, go to IDLE.
//   - IDLE->BURST costs one cycle. Rows therefore start at least N+ROW_GAP+1 enabled
//     cycles apart.
// - Latency: the last word of a row written in cycle t (enable=1, FSM IDLE, no pending
//   bank) gives first sm_in_valid at t+2. Beats are exactly N consecutive enabled cycles.
// - Simultaneous events: a bank completing fill in the same cycle another bank is
//   released applies both updates; no transfer is lost. Both banks full -> s_ready=0
//   until the burst's last beat. The freed bank accepts data the next cycle.
// - enable low mid-burst: sm_in_valid and sm_qin stay at their held value. Softmax
//   ignores them while stalled, so no beat is duplicated or dropped. Rows are never split.
// - Bank words are stored verbatim; no arithmetic, saturation or sign change.
// TESTING
// - Reset, then write 32 words 0..31 with s_valid=1 and enable=1 -> sm_in_valid high for
//   exactly 32 cycles carrying 0..31, starting 2 cycles after word 31. row_sent on the
//   beat carrying 31.
// - Stream 3 rows back to back (96 words) -> s_ready drops after word 63. It rises the
//   cycle after row 0's row_sent. Burst starts are exactly 32+36+1=69 cycles apart.
// - Drop enable for 5 cycles during beat 10 of a burst -> sm_qin holds the value 10 and
//   sm_in_valid holds 1. The burst resumes at 11 and still ends after 32 enabled beats.
// - Assert rst=0 mid-fill (word 17) and mid-burst -> outputs go to 0 immediately. The
//   next row is written fresh and emitted intact; no stale words are emitted.
// - Words 0x7FFFFFFF, 0x80000000, -1 -> emitted bit-exact on sm_qin.
// - Drive the softmax instance with N=32 and 3 rows from this block -> softmax
//   out_valid produces 3x32 outputs that match the golden model.

Source files
------------

// File: rtl/softmax_row_feeder.sv
// Ping-pong row buffer in front of softmax: fills two N-word banks from a valid/ready
// stream and bursts each complete row as N back-to-back beats followed by a fixed idle gap.
module softmax_row_feeder #(
  parameter int D_W_ACC = 32,
  parameter int N       = 32,
  parameter int ROW_GAP = N + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [D_W_ACC-1:0] s_data,
  output logic               sm_in_valid,
  output logic [D_W_ACC-1:0] sm_qin,
  output logic               row_sent,
  output logic               busy
);

  localparam int IDX_W = $clog2(N);
  localparam int ADR_W = IDX_W + 1;
  localparam int GAP_W = $clog2(ROW_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [GAP_W-1:0] LAST_GAP   = GAP_W'(ROW_GAP - 1);
  localparam logic [ADR_W-1:0] BANK1_BASE = ADR_W'(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [D_W_ACC-1:0] mem_r [0:2*N-1];
  state_t             state_r;
  logic [1:0]         full_r;
  logic               wr_bank_r;
  logic               rd_bank_r;
  logic [IDX_W-1:0]   wr_idx_r;
  logic [IDX_W-1:0]   rd_idx_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               fill_s;
  logic [ADR_W-1:0]   wr_addr_s;
  logic [ADR_W-1:0]   rd_addr_s;

  // The write bank only refuses data while it still holds an unsent row.
  assign s_ready   = ~full_r[wr_bank_r] & rst;
  assign fill_s    = s_valid & s_ready;
  assign wr_addr_s = {1'b0, wr_idx_r} + (wr_bank_r ? BANK1_BASE : ADR_W'(0));
  assign rd_addr_s = {1'b0, rd_idx_r} + (rd_bank_r ? BANK1_BASE : ADR_W'(0));
  assign busy      = (state_r != ST_IDLE) | (|full_r);

  // Bank storage; contents are qualified by full_r, so no reset is needed.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      mem_r[wr_addr_s] <= s_data;
    end
  end

  // Fill bookkeeping (always live) and the enable-gated burst FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= '0;
      rd_idx_r    <= '0;
      gap_cnt_r   <= '0;
      sm_in_valid <= 1'b0;
      sm_qin      <= '0;
      row_sent    <= 1'b0;
    end else begin
      if (fill_s) begin
        if (wr_idx_r == LAST_IDX) begin
          full_r[wr_bank_r] <= 1'b1;
          wr_idx_r          <= '0;
          wr_bank_r         <= ~wr_bank_r;
        end else begin
          wr_idx_r <= wr_idx_r + IDX_W'(1);
        end
      end
      // A filling bank is never the one being released, so both full_r updates can coexist.
      if (enable) begin
        case (state_r)
          ST_IDLE: begin
            sm_in_valid <= 1'b0;
            row_sent    <= 1'b0;
            if (full_r[rd_bank_r]) begin
              state_r  <= ST_BURST;
              rd_idx_r <= '0;
            end
          end
          ST_BURST: begin
            sm_in_valid <= 1'b1;
            sm_qin      <= mem_r[rd_addr_s];
            if (rd_idx_r == LAST_IDX) begin
              row_sent          <= 1'b1;
              full_r[rd_bank_r] <= 1'b0;
              rd_bank_r         <= ~rd_bank_r;
              rd_idx_r          <= '0;
              gap_cnt_r         <= '0;
              state_r           <= ST_GAP;
            end else begin
              row_sent <= 1'b0;
              rd_idx_r <= rd_idx_r + IDX_W'(1);
            end
          end
          ST_GAP: begin
            sm_in_valid <= 1'b0;
            row_sent    <= 1'b0;
            if (gap_cnt_r == LAST_GAP) begin
              state_r <= ST_IDLE;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            sm_in_valid <= 1'b0;
            row_sent    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
